vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator for the 640x480 @ 60 Hz VGA output. Divides the system clock down to a pixel-rate tick, runs the horizontal and vertical pixel counters, and drives the monitor sync pulses. Its `HCount`/`VCount` outputs are the raster coordinates consumed by every object renderer (shape ROM lookups, bounding-box tests) and by the RGB output mux.

## Interface
Parameters:
- `PIX_DIV`, 2: system clocks per pixel; 2 gives a 25 MHz pixel rate from 50 MHz; legal range ≥ 1.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `reset` input 1: synchronous, active-high.
- `HCount` output 10: current pixel column, range 0..H_TOTAL-1.
- `VCount` output 10: current line, range 0..V_TOTAL-1.
- `hsync` output 1: horizontal sync, active-low.
- `vsync` output 1: vertical sync, active-low.
- `video_on` output 1: high while the raster position is inside the visible area.
- `pixel_tick` output 1: one-`clk` pulse on each `clk` cycle at which the counters advance.
- `frame_start` output 1: one-`clk` pulse when the raster wraps to (0,0).

## Operation
- Derived totals: H_TOTAL = 800 and V_TOTAL = 525 with default parameters.
- Divider:
  - `div_cnt` counts 0..PIX_DIV-1 and wraps to 0.
  - `pixel_tick` = (`div_cnt` == PIX_DIV-1), decoded from the registered `div_cnt`.
  - With PIX_DIV = 1, `pixel_tick` is constantly 1 after reset.
- Horizontal counter: on a `clk` edge with `pixel_tick` = 1:
  - `HCount` == H_TOTAL-1 → `HCount` becomes 0.
  - Otherwise `HCount` increments by 1.
- Vertical counter: advances only on the same edge where `HCount` wraps:
  - `VCount` == V_TOTAL-1 → `VCount` becomes 0.
  - Otherwise `VCount` increments by 1.
- Sync decode, for the counter values after the edge:
  - `hsync` = 0 iff H_DISPLAY+H_FRONT ≤ `HCount` ≤ H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - `vsync` = 0 iff V_DISPLAY+V_FRONT ≤ `VCount` ≤ V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
  - `video_on` = (`HCount` < H_DISPLAY) && (`VCount` < V_DISPLAY).
- `hsync`, `vsync` and `video_on` are registered: computed from next-state counter values, so they are always consistent with the `HCount`/`VCount` visible in the same cycle and glitch-free.
- `frame_start` is registered. It is high for exactly one `clk` cycle: the cycle following the edge on which the counters go from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- All counter arithmetic is 10-bit unsigned. Out-of-range values are unreachable; no saturation is needed.

## Timing
- Reset is synchronous. While `reset` is high, every edge forces:
  - `div_cnt`=0, `HCount`=0, `VCount`=0
  - `hsync`=1, `vsync`=1, `video_on`=1
  - `frame_start`=0, and therefore `pixel_tick`=0 (for PIX_DIV ≥ 2).
- Reset asserted mid-line or mid-frame: outputs take the reset values on the next edge. No partial sync pulse is held and no `frame_start` pulse is generated.
- After `reset` deasserts, the first `pixel_tick` occurs at the PIX_DIV-th `clk` cycle. The first `HCount` increment (0→1) is visible on the following cycle.
- Each raster position lasts exactly PIX_DIV `clk` cycles.
- Line period = H_TOTAL·PIX_DIV clocks (1600 at default). Frame period = H_TOTAL·V_TOTAL·PIX_DIV clocks (840000 at default).
- Latency from a counter value to its decoded `hsync`/`vsync`/`video_on`: 0 cycles, because they share the same register edge.
- End-of-frame boundary: `HCount` wrap, `VCount` wrap and `frame_start` assertion all take effect on a single edge. `vsync` is already 1 at that point (line 524 lies outside the sync window).

## Test plan
- Reset: hold `reset` 3 clks at an arbitrary point → `HCount`=0, `VCount`=0, `hsync`=1, `vsync`=1, `video_on`=1, `pixel_tick`=0, `frame_start`=0. First `pixel_tick` appears 2 clks after release (PIX_DIV=2).
- Pixel cadence: run 10 pixels → `pixel_tick` on every 2nd clk; `HCount` steps 0,1,…,10, each value lasting 2 clks.
- Horizontal timing:
  - `hsync` falls on the same cycle `HCount` becomes 656 and rises when it becomes 752.
  - `video_on` falls when `HCount` becomes 640.
  - At 799→0, `VCount` increments by 1.
- Vertical timing, over one full frame:
  - `vsync` low exactly while `VCount` ∈ {490, 491} (3200 clks).
  - `video_on` stays 0 for all `VCount` ≥ 480.
- Frame wrap: at (799,524)→(0,0), `frame_start` is high for exactly 1 clk. Consecutive `frame_start` pulses are 840000 clks apart.
- Mid-frame reset: assert `reset` at (700,491) with `hsync`=0 and `vsync`=0 → next edge gives (0,0) with both syncs = 1 and `frame_start` = 0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// Raster timing generator for 640x480 @ 60 Hz VGA: pixel-rate divider, H/V raster
// counters and registered sync/blanking decode aligned with the counters.
module vga_sync_gen #(
    parameter int PIX_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             line_end;
    logic             frame_end;

    function automatic logic in_window(input logic [9:0] pos,
                                       input logic [9:0] first,
                                       input logic [9:0] last);
        return (pos >= first) && (pos <= last);
    endfunction

    // With PIX_DIV = 1 the divider never leaves 0, so the tick is permanently high.
    assign pixel_tick = (div_cnt == DIV_LAST);

    always_comb begin
        div_next  = pixel_tick ? '0 : div_cnt + DIV_W'(1);
        h_next    = HCount;
        v_next    = VCount;
        line_end  = pixel_tick && (HCount == H_LAST);
        frame_end = line_end && (VCount == V_LAST);
        if (pixel_tick) begin
            h_next = line_end ? 10'd0 : HCount + 10'd1;
        end
        if (line_end) begin
            v_next = (VCount == V_LAST) ? 10'd0 : VCount + 10'd1;
        end
    end

    // Decodes are taken from the next-state counters so they land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            HCount      <= 10'd0;
            VCount      <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_next;
            HCount      <= h_next;
            VCount      <= v_next;
            hsync       <= !in_window(h_next, HS_FIRST, HS_LAST);
            vsync       <= !in_window(v_next, VS_FIRST, VS_LAST);
            video_on    <= (h_next < H_VIS) && (v_next < V_VIS);
            frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full horizontal timing with a shortened vertical frame,
// checked every cycle against an arithmetic raster model plus literal expectations.
module tb_vga_sync_gen;

    localparam int D  = 2;
    localparam int HD = 640, HF = 16, HS = 96, HB = 48;
    localparam int VD = 4,   VF = 1,  VS = 2,  VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] HCount, VCount;
    logic       hsync, vsync, video_on, pixel_tick, frame_start;

    int n = 0;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int fs_cnt = 0;
    int last_fs = 0;
    bit chk_en = 1'b0;

    vga_sync_gen #(
        .PIX_DIV(D), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .HCount(HCount), .VCount(VCount),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_tick(pixel_tick), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // n = clock edges since the last edge that sampled reset high
    always @(posedge clk) begin
        n   <= reset ? 0 : n + 1;
        cyc <= cyc + 1;
    end

    function automatic logic [24:0] model(input int k);
        int p, h, v;
        logic hs, vs, vo, tk, fs;
        p  = k / D;
        h  = p % HT;
        v  = (p / HT) % VT;
        hs = !((h >= HD + HF) && (h < HD + HF + HS));
        vs = !((v >= VD + VF) && (v < VD + VF + VS));
        vo = (h < HD) && (v < VD);
        tk = (k % D) == D - 1;
        fs = (k > 0) && (k % D == 0) && (p % (HT * VT) == 0);
        return {10'(h), 10'(v), hs, vs, vo, tk, fs};
    endfunction

    always @(negedge clk) begin
        logic [24:0] exp_v, got_v;
        if (chk_en) begin
            exp_v = model(n);
            got_v = {HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL raster n=%0d got H=%0d V=%0d hs=%b vs=%b von=%b tick=%b fs=%b required H=%0d V=%0d hs=%b vs=%b von=%b tick=%b fs=%b",
                         n, HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start,
                         exp_v[24:15], exp_v[14:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
            if (frame_start === 1'b1) begin
                if (fs_cnt > 0) begin
                    n_cmp++;
                    if (cyc - last_fs != 12800) begin
                        n_bad++;
                        $display("FAIL frame_period got %0d clks required 12800", cyc - last_fs);
                    end
                end
                fs_cnt++;
                last_fs = cyc;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic goto(input int target);
        int budget;
        budget = 0;
        while (n < target && budget < 60000) begin
            @(negedge clk);
            budget++;
        end
        if (n != target) begin
            n_bad++;
            $display("FAIL goto_%0d got n=%0d required %0d", target, n, target);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        goto(37);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_H", HCount, 0);
        chk("rst_V", VCount, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_video_on", video_on, 1);
        chk("rst_tick", pixel_tick, 0);
        chk("rst_frame_start", frame_start, 0);

        goto(1);     chk("tick_first", pixel_tick, 1);  chk("H_n1", HCount, 0);
        goto(2);     chk("tick_n2", pixel_tick, 0);     chk("H_n2", HCount, 1);
        goto(20);    chk("H_n20", HCount, 10);
        goto(1279);  chk("von_639", video_on, 1);
        goto(1280);  chk("H_640", HCount, 640);         chk("von_640", video_on, 0);
        goto(1311);  chk("hs_655", hsync, 1);
        goto(1312);  chk("H_656", HCount, 656);         chk("hs_656", hsync, 0);
        goto(1503);  chk("hs_751", hsync, 0);
        goto(1504);  chk("hs_752", hsync, 1);
        goto(1599);  chk("H_799", HCount, 799);         chk("V_line0", VCount, 0);
        goto(1600);  chk("H_wrap", HCount, 0);          chk("V_line1", VCount, 1);
        goto(6400);  chk("V_4", VCount, 4);             chk("von_V4", video_on, 0);
        goto(7999);  chk("vs_before", vsync, 1);
        goto(8000);  chk("V_5", VCount, 5);             chk("vs_first", vsync, 0);
        goto(11199); chk("vs_last", vsync, 0);
        goto(11200); chk("vs_after", vsync, 1);
        goto(12799); chk("fs_pre", frame_start, 0);     chk("V_7", VCount, 7);
        goto(12800); chk("fs_wrap", frame_start, 1);    chk("H_fwrap", HCount, 0);
        chk("V_fwrap", VCount, 0);
        goto(12801); chk("fs_one_clk", frame_start, 0);
        goto(25601);

        goto(36600);
        chk("mid_H", HCount, 700);
        chk("mid_V", VCount, 6);
        chk("mid_hs", hsync, 0);
        chk("mid_vs", vsync, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_H", HCount, 0);
        chk("mrst_V", VCount, 0);
        chk("mrst_hs", hsync, 1);
        chk("mrst_vs", vsync, 1);
        chk("mrst_fs", frame_start, 0);
        reset = 1'b0;
        goto(200);
        chk("fs_pulses", fs_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
